// File: rtl/ps2_rx_byte_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_byte_if
// Brief    : PS/2 line inputs and received-byte outputs of ps2_rx_byte.
// Revision : 1.0
// ============================================================================
interface ps2_rx_byte_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       rx_timeout;

  modport master (
    input  ps2c, ps2d, rx_en,
    output rx_done_tick, dout, parity_err, frame_err, rx_timeout
  );

  modport slave (
    output ps2c, ps2d, rx_en,
    input  rx_done_tick, dout, parity_err, frame_err, rx_timeout
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_byte
// Brief    : PS/2 device-to-host receiver: sync, glitch filter, 11-bit deserialiser.
// Revision : 1.0
// ============================================================================
module ps2_rx_byte #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_byte_if.master  bus
);

  localparam int             WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_t;

  logic                  ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_edge;
  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  // The start bit is shifted out the bottom; only data, parity and stop are kept.
  logic [10:1]           b_q, b_d, b_shift;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [7:0]            dout_q, dout_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_timeout_q, rx_timeout_d;
  logic                  done_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_q  <= 1'b1;
      ps2c_sync_q  <= 1'b1;
      ps2d_meta_q  <= 1'b1;
      ps2d_sync_q  <= 1'b1;
      filter_q     <= '1;
      fclk_q       <= 1'b1;
      state_q      <= IDLE;
      n_q          <= 4'd0;
      b_q          <= '0;
      wdog_q       <= '0;
      dout_q       <= 8'h00;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      ps2c_meta_q  <= bus.ps2c;
      ps2c_sync_q  <= ps2c_meta_q;
      ps2d_meta_q  <= bus.ps2d;
      ps2d_sync_q  <= ps2d_meta_q;
      filter_q     <= filter_d;
      fclk_q       <= fclk_d;
      state_q      <= state_d;
      n_q          <= n_d;
      b_q          <= b_d;
      wdog_q       <= wdog_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  always_comb begin
    filter_d     = {ps2c_sync_q, filter_q[FILTER_LEN-1:1]};
    fclk_d       = fclk_q;
    state_d      = state_q;
    n_d          = n_q;
    b_d          = b_q;
    wdog_d       = '0;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_timeout_d = 1'b0;
    done_tick    = 1'b0;

    if (&filter_q) begin
      fclk_d = 1'b1;
    end else if (~|filter_q) begin
      fclk_d = 1'b0;
    end
    fall_edge = fclk_q & ~fclk_d;
    b_shift   = {ps2d_sync_q, b_q[10:2]};

    case (state_q)
      IDLE: begin
        if (fall_edge && bus.rx_en && !ps2d_sync_q) begin
          b_d     = b_shift;
          n_d     = 4'd9;
          state_d = DPS;
        end
      end
      DPS: begin
        if (fall_edge) begin
          b_d = b_shift;
          if (n_q == 4'd0) begin
            // Result is captured at the stop edge so it is already valid during the LOAD tick.
            state_d      = LOAD;
            dout_d       = b_shift[8:1];
            parity_err_d = ~(^b_shift[9:1]);
            frame_err_d  = ~b_shift[10];
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (wdog_q == WD_LAST) begin
          state_d      = IDLE;
          rx_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      LOAD: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_done_tick = done_tick;
  assign bus.dout         = dout_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.rx_timeout   = rx_timeout_q;

endmodule
`default_nettype wire
